// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to DMA_REG and copies LENGTH bytes from
// {page,8'h00} into OAM, reading through a synchronous RAM with one cycle of latency.
module oam_dma #(
  parameter int          LENGTH  = 160,
  parameter logic [15:0] DMA_REG = 16'hFF46
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_data,
  output logic [15:0] mem_addr,
  output logic        mem_wren,
  input  logic [7:0]  mem_data_out,
  output logic [7:0]  oam_addr,
  output logic        oam_wren,
  output logic [7:0]  oam_data,
  output logic        dma_active,
  output logic [7:0]  dma_reg
);

  typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_e;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wr_idx_q, wr_idx_d;
  logic        trigger;
  logic [7:0]  src_hi;

  assign trigger = cpu_wren && (cpu_addr == DMA_REG);
  // Pages E0..FF are echo RAM and alias C0..DF.
  assign src_hi  = (cpu_data >= 8'hE0) ? (cpu_data - 8'h20) : cpu_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (trigger) begin
      state_d = START;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        START:   state_d = XFER;
        XFER:    state_d = (index_q == LAST_IDX) ? DRAIN : XFER;
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      index_q   <= 8'h00;
      base_q    <= 16'h0000;
      dma_reg_q <= 8'h00;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 8'h00;
    end else begin
      index_q   <= index_d;
      base_q    <= base_d;
      dma_reg_q <= dma_reg_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  // A restart drops the read issued in the trigger cycle, so START never writes.
  always_comb begin
    index_d   = index_q;
    base_d    = base_q;
    dma_reg_d = dma_reg_q;
    wr_pend_d = (state_q == XFER) && !trigger;
    wr_idx_d  = index_q;
    if (state_q == START) begin
      index_d = 8'h00;
    end else if (state_q == XFER) begin
      index_d = index_q + 8'd1;
    end
    if (trigger) begin
      dma_reg_d = cpu_data;
      base_d    = {src_hi, 8'h00};
    end
  end

  always_comb begin
    mem_addr   = (state_q == XFER) ? (base_q + {8'h00, index_q}) : 16'h0000;
    mem_wren   = 1'b0;
    oam_wren   = wr_pend_q;
    oam_addr   = wr_pend_q ? wr_idx_q : 8'h00;
    oam_data   = wr_pend_q ? mem_data_out : 8'h00;
    dma_active = (state_q != IDLE);
    dma_reg    = dma_reg_q;
  end

endmodule
